// File: rtl/round_key_xor_stage.sv
// Round-key addition: XORs each accepted state block with a key selected by its round index.
// Latency 1 cycle; the one-deep output register stalls in_ready while a result is held and out_ready is low.
module round_key_xor_stage #(
    parameter int DATA_W   = 128,
    parameter int NUM_KEYS = 15,
    parameter int IDX_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_wr_en,
    input  logic [IDX_W-1:0]  key_wr_idx,
    input  logic [DATA_W-1:0] key_wr_data,
    input  logic              key_clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [IDX_W-1:0]  in_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_err,
    output logic [7:0]        err_count
);

    logic [DATA_W-1:0]   key_mem [NUM_KEYS];
    logic [NUM_KEYS-1:0] loaded;

    logic              accept;
    logic              wr_ok;
    logic              idx_ok;
    logic              hit;
    logic [DATA_W-1:0] sel_key;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign wr_ok    = key_wr_en && (32'(key_wr_idx) < 32'(NUM_KEYS));
    assign idx_ok   = 32'(in_idx) < 32'(NUM_KEYS);

    // Table is read combinationally here, so a same-cycle write only lands after this block is captured.
    always_comb begin
        sel_key = '0;
        hit     = 1'b0;
        if (idx_ok) begin
            sel_key = key_mem[in_idx];
            hit     = loaded[in_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_mem[i] <= '0;
            end
            loaded <= '0;
        end else begin
            if (key_clear) begin
                loaded <= '0;
            end
            // Placed after the clear so a write to the same entry keeps it loaded.
            if (wr_ok) begin
                key_mem[key_wr_idx] <= key_wr_data;
                loaded[key_wr_idx]  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_err   <= 1'b0;
            err_count <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_idx   <= in_idx;
            out_err   <= !hit;
            out_data  <= hit ? (in_data ^ sel_key) : in_data;
            if (!hit && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_round_key_xor_stage.sv
// Directed and randomized checks of round_key_xor_stage against a transaction-level key-table model.
module tb_round_key_xor_stage;

    localparam int DW = 128;
    localparam int NK = 15;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          key_wr_en;
    logic [IW-1:0] key_wr_idx;
    logic [DW-1:0] key_wr_data;
    logic          key_clear;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [IW-1:0] in_idx;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic          out_err;
    logic [7:0]    err_count;

    round_key_xor_stage #(.DATA_W(DW), .NUM_KEYS(NK)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
        .key_clear(key_clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_idx(in_idx),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_err(out_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
        logic          err;
    } result_t;

    // Reference state: key table, loaded flags, the block currently offered downstream, error tally.
    logic [DW-1:0] m_key [NK];
    bit            m_loaded [NK];
    bit            m_held;
    result_t       m_res;
    int            m_errs;
    bit            last_acc;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_edge();
        bit      acc;
        bit      ok;
        result_t r;
        if (!rst_n) begin
            for (int i = 0; i < NK; i++) begin
                m_key[i]    = '0;
                m_loaded[i] = 0;
            end
            m_held   = 0;
            m_res    = '{data: '0, idx: '0, err: 1'b0};
            m_errs   = 0;
            last_acc = 0;
            return;
        end
        acc = in_valid && (!m_held || out_ready);
        if (acc) begin
            ok     = (int'(in_idx) < NK) && m_loaded[in_idx];
            r.idx  = in_idx;
            r.err  = !ok;
            r.data = ok ? (in_data ^ m_key[in_idx]) : in_data;
            m_res  = r;
            m_held = 1;
            if (!ok) m_errs = (m_errs < 255) ? m_errs + 1 : 255;
        end else if (out_ready) begin
            m_held = 0;
        end
        if (key_clear) begin
            for (int i = 0; i < NK; i++) m_loaded[i] = 0;
        end
        if (key_wr_en && int'(key_wr_idx) < NK) begin
            m_key[key_wr_idx]    = key_wr_data;
            m_loaded[key_wr_idx] = 1;
        end
        last_acc = acc;
    endtask

    task automatic step();
        #1;
        if (rst_n) chk("in_ready", in_ready, (!m_held || out_ready));
        @(posedge clk);
        model_edge();
        #1;
        chk("out_valid", out_valid, m_held);
        chk("out_data", out_data, m_res.data);
        chk("out_idx", out_idx, m_res.idx);
        chk("out_err", out_err, m_res.err);
        chk("err_count", err_count, m_errs[7:0]);
    endtask

    task automatic idle();
        key_wr_en = 0;
        key_clear = 0;
        in_valid  = 0;
    endtask

    task automatic wr_key(input int idx, input logic [DW-1:0] k);
        key_wr_en   = 1;
        key_wr_idx  = IW'(idx);
        key_wr_data = k;
    endtask

    task automatic send(input int idx, input logic [DW-1:0] d);
        in_valid = 1;
        in_idx   = IW'(idx);
        in_data  = d;
    endtask

    logic [DW-1:0] d0;
    int            blk;

    initial begin
        rst_n = 0; out_ready = 1; idle();
        key_wr_idx = '0; key_wr_data = '0; in_idx = '0; in_data = '0;
        step(); step();
        rst_n = 1;
        step();

        // FIPS-197 AddRoundKey example
        wr_key(0, 128'h000102030405060708090a0b0c0d0e0f);
        step(); idle();
        send(0, 128'h00112233445566778899aabbccddeeff);
        step(); idle();
        chk("fips_data", out_data, 128'h00102030405060708090a0b0c0d0e0f0);
        chk("fips_err", out_err, 1'b0);
        step();

        // Backpressure: out_ready low during cycles 2..4 of a 4-block stream
        for (int i = 1; i < 4; i++) begin
            wr_key(i, rnd128());
            step();
        end
        idle();
        blk = 0;
        d0  = rnd128();
        for (int c = 1; c <= 10; c++) begin
            out_ready = !(c >= 2 && c <= 4);
            if (blk < 4) send(blk, d0 + DW'(blk)); else in_valid = 0;
            step();
            if (last_acc) blk++;
        end
        chk("bp_all_accepted", DW'(blk), DW'(4));
        out_ready = 1; idle();

        // Unloaded index and out-of-range index
        d0 = rnd128();
        send(5, d0); step(); idle();
        chk("err_idx5_data", out_data, d0);
        chk("err_idx5_cnt", err_count, 8'd1);
        send(NK, rnd128()); step(); idle();
        chk("err_oor_flag", out_err, 1'b1);

        // Read-before-write collision on entry 2
        wr_key(2, '0); step(); idle();
        d0 = rnd128();
        wr_key(2, '1); send(2, d0); step(); idle();
        chk("collide_old", out_data, d0);
        send(2, d0); step(); idle();
        chk("collide_new", out_data, ~d0);

        // key_clear, then clear racing a write to entry 1
        key_clear = 1; step(); idle();
        send(0, rnd128()); step(); idle();
        chk("clear_err", out_err, 1'b1);
        key_clear = 1; wr_key(1, rnd128()); step(); idle();
        send(1, rnd128()); step(); idle();
        chk("clear_wr_ok", out_err, 1'b0);

        // Randomized traffic
        for (int c = 0; c < 300; c++) begin
            key_wr_en   = ($urandom_range(0, 3) == 0);
            key_wr_idx  = IW'($urandom_range(0, 15));
            key_wr_data = rnd128();
            key_clear   = ($urandom_range(0, 40) == 0);
            in_valid    = ($urandom_range(0, 3) != 0);
            in_idx      = IW'($urandom_range(0, 15));
            in_data     = rnd128();
            out_ready   = ($urandom_range(0, 2) != 0);
            step();
        end
        idle(); out_ready = 1;
        step();

        // Saturation of the error counter
        key_clear = 1; step(); idle();
        for (int i = 0; i < 300; i++) begin
            send(NK, rnd128());
            step();
        end
        idle();
        chk("err_sat", err_count, 8'd255);

        // Reset while a result is held under backpressure
        wr_key(0, rnd128()); step(); idle();
        send(0, rnd128()); out_ready = 0; step(); idle();
        chk("held_before_rst", out_valid, 1'b1);
        rst_n = 0; step();
        rst_n = 1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_cnt", err_count, 8'd0);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        out_ready = 1;
        send(0, rnd128()); step(); idle();
        chk("rst_keys_gone", out_err, 1'b1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/round_key_xor_stage.md
# round_key_xor_stage

Registered, parametrised round-key addition stage for the AES datapath. It holds a loadable table of round keys and XORs each accepted state block with the entry selected by its round index. Results leave through a one-deep valid/ready pipeline register with backpressure. It replaces the purely combinational key addition wherever the round loop or unrolled pipeline needs a registered, flow-controlled stage.

## Interface
Parameters:
- DATA_W, 128: state/key width in bits; any multiple of 8 ≥ 8.
- NUM_KEYS, 15: round-key table depth (15 covers AES-256; 11 for AES-128).
- IDX_W, $clog2(NUM_KEYS) (min 1): round-index width; derived, not overridden.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- key_wr_en  in  1  write key_wr_data into table entry key_wr_idx.
- key_wr_idx  in  IDX_W  table write address.
- key_wr_data  in  DATA_W  round key.
- key_clear  in  1  invalidate all table entries (contents kept, loaded bits cleared).
- in_valid  in  1  input block present.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  state block.
- in_idx  in  IDX_W  round index selecting the key.
- out_valid  out  1  result held.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  in_data ^ key[in_idx].
- out_idx  out  IDX_W  round index carried with result.
- out_err  out  1  result produced without a valid key.
- err_count  out  8  saturating count of errored blocks.

## Operation
- Key table: NUM_KEYS × DATA_W registers plus one loaded bit per entry.
- key_wr_en with key_wr_idx < NUM_KEYS: writes the entry and sets its loaded bit. A write with an index ≥ NUM_KEYS is ignored.
- key_clear clears all loaded bits. If key_clear and key_wr_en occur in the same cycle, the write wins for its entry (its loaded bit ends at 1).
- Accept: in_valid && in_ready. in_ready = !out_valid || out_ready (combinational from out_ready; no skid).
- On accept, with in_idx < NUM_KEYS and the entry loaded: out_data = in_data ^ key[in_idx], out_err = 0.
- On accept, otherwise: out_data = in_data (unmodified), out_err = 1, err_count += 1, saturating at 255.
- out_idx is a registered copy of in_idx.
- Same-cycle key write to the entry being read: the accepted block uses the pre-write key (read-before-write). key_clear in the accept cycle likewise does not affect that block.
- Output register: out_valid is set on accept. It is cleared when out_ready && !accept. It stays 1 on simultaneous drain and accept, and new data replaces the old.
- With out_valid && !out_ready, out_data, out_idx and out_err are held stable.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 block/cycle while out_ready = 1.
- Key write to first use: 1 cycle. A block accepted in the cycle after key_wr_en sees the new key.
- Reset (rst_n = 0 at a clock edge) gives:
  - out_valid = 0, out_data = 0, out_idx = 0, out_err = 0, err_count = 0.
  - All keys = 0, all loaded bits = 0.
  - in_ready = 1 from the first cycle after reset.
- Reset mid-operation discards any held result with no output handshake. Keys must be reloaded.
- No other output is combinational from any input except in_ready (from out_ready).

## Test plan
- FIPS-197 vector: load key[0] = 000102030405060708090a0b0c0d0e0f, send in_data = 00112233445566778899aabbccddeeff with idx 0. Expect out_data = 00102030405060708090a0b0c0d0e0f0 one cycle later, out_err = 0.
- Backpressure: stream 4 blocks (idx 0..3, keys loaded) with out_ready low for cycles 2–4. Expect outputs held stable, in_ready = 0 while held, no loss or duplication, order preserved, back-to-back throughput once out_ready = 1.
- Errors:
  - Send a block with unloaded idx 5 → out_data = in_data, out_err = 1, err_count = 1.
  - Send idx = NUM_KEYS (if representable) → out_err = 1.
  - Send 300 error blocks → err_count = 255.
- Collision: write key[2] = all-ones in the same cycle a block with idx 2 (old key all-zero) is accepted. Expect out_data = in_data. The next block with idx 2 gets the inverted data.
- key_clear: clear all entries, then send idx 0 → out_err = 1. With key_clear and key_wr_en on idx 1 in the same cycle, idx 1 stays usable.
- Reset mid-stream: assert rst_n = 0 while out_valid = 1 and out_ready = 0. Expect out_valid = 0, err_count = 0, in_ready = 1 next cycle, and previously loaded keys reporting out_err = 1.
